// File: rtl/tremolo_lfo_multi.sv
// Multi-bank tremolo LFO: one triangle phase counter per register bank,
// depth-scaled attenuation returned two clocks after the lookup slot.
module tremolo_lfo_multi #(
   parameter int NUM_BANKS     = 2,
   parameter int BANK_WIDTH    = 1,
   parameter int OP_WIDTH      = 5,
   parameter int INDEX_WIDTH   = 14,
   parameter int MAX_COUNT     = 13440,
   parameter int STEP_SHIFT    = 8,
   parameter int PEAK          = 26,
   parameter int AM_WIDTH      = 5,
   parameter int SHALLOW_SHIFT = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  sample_clk_en,
   input  logic [BANK_WIDTH-1:0] bank_num,
   input  logic [OP_WIDTH-1:0]   op_num,
   input  logic                  dam,
   input  logic [NUM_BANKS-1:0]  lfo_clear,
   input  logic [NUM_BANKS-1:0]  lfo_hold,
   output logic [AM_WIDTH-1:0]   am_val_p2
);

   localparam logic [INDEX_WIDTH-1:0] LAST_L  = INDEX_WIDTH'(MAX_COUNT - 1);
   localparam logic [INDEX_WIDTH-1:0] PEAK_L  = INDEX_WIDTH'(PEAK);
   localparam logic [INDEX_WIDTH-1:0] PEAK2_L = INDEX_WIDTH'(2 * PEAK);

   logic [INDEX_WIDTH-1:0] r_idx [NUM_BANKS];
   logic [NUM_BANKS-1:0]   w_tick;
   logic [BANK_WIDTH-1:0]  r_bank_p1;
   logic                   r_dam_p1;
   logic [INDEX_WIDTH-1:0] w_idx;
   logic                   w_valid;
   logic [INDEX_WIDTH-1:0] w_raw;
   logic [INDEX_WIDTH-1:0] w_tri_full;
   logic [AM_WIDTH-1:0]    w_tri;

   always_comb begin
      w_tick = '0;
      for (int b = 0; b < NUM_BANKS; b++)
         w_tick[b] = sample_clk_en && (op_num == '0) &&
                     (int'(bank_num) == b);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int b = 0; b < NUM_BANKS; b++)
            r_idx[b] <= '0;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (lfo_clear[b])
               r_idx[b] <= '0;
            else if (lfo_hold[b])
               r_idx[b] <= r_idx[b];
            else if (w_tick[b])
               r_idx[b] <= (r_idx[b] == LAST_L) ? '0 : r_idx[b] + 1'b1;
         end
      end
   end

   // Out-of-range banks select nothing and yield zero attenuation.
   always_comb begin
      w_idx   = '0;
      w_valid = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (int'(r_bank_p1) == b) begin
            w_idx   = r_idx[b];
            w_valid = 1'b1;
         end
      end
   end

   always_comb begin
      w_raw      = w_idx >> STEP_SHIFT;
      w_tri_full = (w_raw <= PEAK_L) ? w_raw : PEAK2_L - w_raw;
      w_tri      = w_valid ? AM_WIDTH'(w_tri_full) : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bank_p1 <= '0;
         r_dam_p1  <= 1'b0;
         am_val_p2 <= '0;
      end else begin
         r_bank_p1 <= bank_num;
         r_dam_p1  <= dam;
         am_val_p2 <= r_dam_p1 ? w_tri : w_tri >> SHALLOW_SHIFT;
      end
   end

endmodule

// File: tb/tb_tremolo_lfo_multi.sv
// Directed bench for tremolo_lfo_multi: ramp, wrap, depth,
// bank independence, hold/clear controls and pipeline latency.
module tb_tremolo_lfo_multi;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       sample_clk_en;
   logic [0:0] bank_num;
   logic [4:0] op_num;
   logic       dam;
   logic [1:0] lfo_clear;
   logic [1:0] lfo_hold;
   logic [4:0] am_val_p2;

   int n_tests = 0;
   int n_fail  = 0;

   tremolo_lfo_multi dut (
      .clk(clk),
      .reset_n(reset_n),
      .sample_clk_en(sample_clk_en),
      .bank_num(bank_num),
      .op_num(op_num),
      .dam(dam),
      .lfo_clear(lfo_clear),
      .lfo_hold(lfo_hold),
      .am_val_p2(am_val_p2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int bank, input int op, input int n);
      @(negedge clk);
      sample_clk_en = 1'b1;
      bank_num      = 1'(bank);
      op_num        = 5'(op);
      dam           = 1'b1;
      repeat (n) @(posedge clk);
   endtask

   task automatic lookup(input string tag, input int bank,
                         input int d, input int exp);
      @(negedge clk);
      sample_clk_en = 1'b0;
      bank_num      = 1'(bank);
      op_num        = 5'd0;
      dam           = d[0];
      @(posedge clk);
      @(posedge clk);
      #1;
      chk(tag, int'(am_val_p2), exp);
   endtask

   int pb [6] = '{0, 1, 0, 1, 0, 1};
   int pd [6] = '{1, 1, 0, 0, 1, 1};
   int pe [6] = '{26, 2, 6, 0, 26, 2};

   initial begin
      reset_n       = 1'b0;
      sample_clk_en = 1'b0;
      bank_num      = '0;
      op_num        = '0;
      dam           = 1'b0;
      lfo_clear     = '0;
      lfo_hold      = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out", int'(am_val_p2), 0);
      @(negedge clk);
      reset_n = 1'b1;

      tick(0, 0, 256);
      lookup("ramp_256", 0, 1, 1);
      tick(0, 0, 6400);
      lookup("ramp_6656_deep", 0, 1, 26);
      lookup("ramp_6656_shallow", 0, 0, 6);
      tick(0, 0, 256);
      lookup("ramp_6912", 0, 1, 25);
      tick(0, 0, 6527);
      lookup("wrap_13439", 0, 1, 0);
      tick(0, 0, 1);
      tick(0, 0, 256);
      lookup("wrap_restart", 0, 1, 1);

      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("async_reset", int'(am_val_p2), 0);
      @(negedge clk);
      reset_n = 1'b1;
      lookup("reset_idx0", 0, 1, 0);

      tick(1, 0, 512);
      lookup("bank1_512", 1, 1, 2);
      lookup("bank0_idle", 0, 1, 0);
      tick(1, 3, 256);
      lookup("opnz_bank1", 1, 1, 2);
      lookup("opnz_bank0", 0, 1, 0);

      tick(0, 0, 768);
      lookup("pre_hold", 0, 1, 3);
      lfo_hold = 2'b01;
      tick(0, 0, 1000);
      lfo_hold = 2'b00;
      lookup("hold", 0, 1, 3);
      @(negedge clk);
      lfo_clear     = 2'b01;
      lfo_hold      = 2'b01;
      sample_clk_en = 1'b1;
      bank_num      = 1'b0;
      op_num        = 5'd0;
      @(posedge clk);
      @(negedge clk);
      lfo_clear = 2'b00;
      lfo_hold  = 2'b00;
      lookup("clear_bank0", 0, 1, 0);
      lookup("clear_bank1", 1, 1, 2);

      tick(0, 0, 6656);
      for (int i = 0; i <= 6; i++) begin
         @(negedge clk);
         sample_clk_en = 1'b0;
         op_num        = 5'd0;
         if (i < 6) begin
            bank_num = 1'(pb[i]);
            dam      = pd[i][0];
         end
         @(posedge clk);
         #1;
         if (i >= 1)
            chk($sformatf("pipe_%0d", i - 1), int'(am_val_p2), pe[i - 1]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
